digi_src_mux: RTL and testbench

DIGI_SRC_MUX -- requirements
Module: digi_src_mux

---
 rtl/digi_src_mux_if.sv | 47 ++++
 rtl/digi_src_mux.sv | 155 +++++++++++++++
 tb/tb_digi_src_mux.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/digi_src_mux_if.sv
// Bus bundle between the DIGI source multiplexer and its environment.
//
// Consumer side (one entry per lane):
//   lane_re     consumer read enable
//   lane_empty  empty flag presented to the consumer
//   lane_data   muxed data, lane i at [i*DATA_W +: DATA_W]
// Source side (index s*NLANES+i for source s, lane i):
//   src_re      read enables to the source FIFOs
//   src_empty   source FIFO empty flags
//   src_data    source FIFO data, word at [(s*NLANES+i)*DATA_W +: DATA_W]
//
// Modports: master = environment (consumer plus sources), slave = the mux.

`ifndef DIGI_BITS
`define DIGI_BITS 16
`endif

interface digi_src_mux_if #(
  parameter int unsigned NLANES = 4,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned DATA_W = `DIGI_BITS
);
  logic [NLANES-1:0]             lane_re;
  logic [NLANES-1:0]             lane_empty;
  logic [NLANES*DATA_W-1:0]      lane_data;
  logic [NSRC*NLANES-1:0]        src_re;
  logic [NSRC*NLANES-1:0]        src_empty;
  logic [NSRC*NLANES*DATA_W-1:0] src_data;

  modport master (
    output lane_re,
    input  lane_empty,
    input  lane_data,
    input  src_re,
    output src_empty,
    output src_data
  );

  modport slave (
    input  lane_re,
    output lane_empty,
    output lane_data,
    output src_re,
    input  src_empty,
    input  src_data
  );
endinterface

// File: rtl/digi_src_mux.sv
// DIGI readout source multiplexer.
//
// Selects one of NSRC data sources (real DIGI, simulated DIGI, generators) for all
// NLANES readout lanes. A source change drains in-flight reads for RD_LAT cycles
// (DRAIN), then swaps the active source in a single SWITCH cycle, clearing the
// per-lane word counters.
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   bus          slave side of digi_src_mux_if (lane and source handshakes/data)
//   src_sel      requested source index
//   cur_src      source currently in use
//   switching    high in DRAIN and SWITCH
//   switch_done  one-cycle pulse in the SWITCH cycle
//   sel_err      sticky: an out-of-range src_sel was seen in RUN
//   word_cnt     per-lane saturating count of granted reads since the last switch

`ifndef DIGI_BITS
`define DIGI_BITS 16
`endif

module digi_src_mux #(
  parameter int unsigned NLANES = 4,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned DATA_W = `DIGI_BITS,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  digi_src_mux_if.slave           bus,
  input  logic [SEL_W-1:0]        src_sel,
  output logic [SEL_W-1:0]        cur_src,
  output logic                    switching,
  output logic                    switch_done,
  output logic                    sel_err,
  output logic [NLANES*CNT_W-1:0] word_cnt
);

  typedef enum logic [1:0] {StRun, StDrain, StSwitch} state_e;

  localparam logic [2:0]       DrainLoad = 3'(RD_LAT);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  state_e                  state_q, state_d;
  logic [SEL_W-1:0]        cur_src_q, cur_src_d;
  logic [SEL_W-1:0]        tgt_src_q, tgt_src_d;
  logic [2:0]              drain_cnt_q, drain_cnt_d;
  logic                    sel_err_q, sel_err_d;
  logic [NLANES*CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic [NLANES-1:0]        grant;
  logic [NLANES-1:0]        lane_empty;
  logic [NLANES*DATA_W-1:0] lane_data;
  logic [NSRC*NLANES-1:0]   src_re;
  logic                     sel_valid;

  assign sel_valid = 32'(src_sel) < NSRC;

  // Lane routing. Data always follows cur_src, so reads granted before a switch
  // still return from the old source during the drain window.
  always_comb begin
    grant      = '0;
    src_re     = '0;
    lane_empty = '1;
    lane_data  = '0;
    for (int unsigned i = 0; i < NLANES; i++) begin
      for (int unsigned s = 0; s < NSRC; s++) begin
        if (32'(cur_src_q) == s) begin
          lane_data[i*DATA_W +: DATA_W] = bus.src_data[(s*NLANES+i)*DATA_W +: DATA_W];
          if (!reset && state_q == StRun) begin
            lane_empty[i] = bus.src_empty[s*NLANES+i];
            if (bus.lane_re[i] && !bus.src_empty[s*NLANES+i]) begin
              src_re[s*NLANES+i] = 1'b1;
              grant[i]           = 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.src_re     = src_re;
  assign bus.lane_empty = lane_empty;
  assign bus.lane_data  = lane_data;

  always_comb begin
    state_d     = state_q;
    cur_src_d   = cur_src_q;
    tgt_src_d   = tgt_src_q;
    drain_cnt_d = drain_cnt_q;
    sel_err_d   = sel_err_q;
    word_cnt_d  = word_cnt_q;

    for (int unsigned i = 0; i < NLANES; i++) begin
      if (grant[i] && word_cnt_q[i*CNT_W +: CNT_W] != '1) begin
        word_cnt_d[i*CNT_W +: CNT_W] = word_cnt_q[i*CNT_W +: CNT_W] + CntOne;
      end
    end

    unique case (state_q)
      StRun: begin
        if (!sel_valid) begin
          sel_err_d = 1'b1;
        end else if (src_sel != cur_src_q) begin
          tgt_src_d   = src_sel;
          drain_cnt_d = DrainLoad;
          state_d     = StDrain;
        end
      end
      StDrain: begin
        // Counter hits 0 on the edge into SWITCH: RD_LAT cycles spent here.
        drain_cnt_d = drain_cnt_q - 3'd1;
        if (drain_cnt_q == 3'd1) begin
          state_d = StSwitch;
        end
      end
      StSwitch: begin
        cur_src_d  = tgt_src_q;
        word_cnt_d = '0;
        state_d    = StRun;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      cur_src_q   <= '0;
      tgt_src_q   <= '0;
      drain_cnt_q <= '0;
      sel_err_q   <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_src_q   <= cur_src_d;
      tgt_src_q   <= tgt_src_d;
      drain_cnt_q <= drain_cnt_d;
      sel_err_q   <= sel_err_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign cur_src     = cur_src_q;
  assign switching   = !reset && (state_q != StRun);
  assign switch_done = !reset && (state_q == StSwitch);
  assign sel_err     = sel_err_q;
  assign word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_digi_src_mux.sv
// Directed bench for digi_src_mux: NLANES=4, NSRC=3, DATA_W=8, RD_LAT=1, CNT_W=4.
// Source s, lane i carries the constant word 0xA0 + 16*s + i. Source 0 lane 0 is a
// small FIFO whose fill level is tracked by the bench; all other empties are direct.
module tb_digi_src_mux;
  localparam int unsigned NLANES = 4;
  localparam int unsigned NSRC   = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned CNT_W  = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [1:0]              src_sel;
  logic [1:0]              cur_src;
  logic                    switching;
  logic                    switch_done;
  logic                    sel_err;
  logic [NLANES*CNT_W-1:0] word_cnt;
  logic [NSRC*NLANES-1:1]  src_empty_drv;

  int fifo0_cnt;
  int total = 0;
  int bad = 0;
  int re_s0, re_s1, re_s2, done_pulses;

  digi_src_mux_if #(.NLANES(NLANES), .NSRC(NSRC), .DATA_W(DATA_W)) bus ();

  assign bus.src_empty = {src_empty_drv, fifo0_cnt == 0};

  digi_src_mux #(
    .NLANES(NLANES),
    .NSRC  (NSRC),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .src_sel    (src_sel),
    .cur_src    (cur_src),
    .switching  (switching),
    .switch_done(switch_done),
    .sel_err    (sel_err),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  // Sample just before the edge, clock, then settle 1 time unit past the edge.
  task automatic step;
    logic pop;
    #1;
    re_s0       += $countones(bus.src_re[3:0]);
    re_s1       += $countones(bus.src_re[7:4]);
    re_s2       += $countones(bus.src_re[11:8]);
    done_pulses += int'(switch_done);
    pop = bus.src_re[0];
    @(posedge clk);
    #1;
    if (pop && fifo0_cnt > 0) fifo0_cnt--;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_cnts;
    re_s0 = 0;
    re_s1 = 0;
    re_s2 = 0;
    done_pulses = 0;
  endtask

  initial begin
    // Reset with every input trying to provoke a read.
    reset         = 1'b1;
    src_sel       = 2'd0;
    bus.lane_re   = '1;
    src_empty_drv = '0;
    fifo0_cnt     = 5;
    for (int s = 0; s < int'(NSRC); s++) begin
      for (int i = 0; i < int'(NLANES); i++) begin
        bus.src_data[(s*NLANES+i)*DATA_W +: DATA_W] = 8'hA0 + 8'(s*16 + i);
      end
    end
    clr_cnts();
    step();
    step();
    chk("rst_src_re", 32'(bus.src_re), 0);
    chk("rst_lane_empty", 32'(bus.lane_empty), 32'hF);
    chk("rst_switching", 32'(switching), 0);
    chk("rst_switch_done", 32'(switch_done), 0);
    chk("rst_cur_src", 32'(cur_src), 0);
    chk("rst_sel_err", 32'(sel_err), 0);
    chk("rst_word_cnt", 32'(word_cnt), 0);

    // Release; source 0 lane 0 holds 3 words, everything else empty.
    reset         = 1'b0;
    bus.lane_re   = '0;
    src_empty_drv = '1;
    fifo0_cnt     = 3;
    step();
    chk("run_lane_empty", 32'(bus.lane_empty), 32'hE);
    chk("run_lane0_data", 32'(bus.lane_data[7:0]), 32'hA0);
    chk("run_lane1_data", 32'(bus.lane_data[15:8]), 32'hA1);

    // Five read attempts on lane 0 against a 3-word FIFO.
    clr_cnts();
    bus.lane_re = 4'b0001;
    repeat (5) step();
    chk("fifo_src0_reads", 32'(re_s0), 3);
    chk("fifo_other_reads", 32'(re_s1 + re_s2), 0);
    chk("fifo_word_cnt", 32'(word_cnt), 32'h0003);
    chk("fifo_drained", 32'(fifo0_cnt), 0);
    chk("fifo_lane0_empty", 32'(bus.lane_empty[0]), 1);

    // Switch 0 -> 1 with a read granted in the request cycle.
    fifo0_cnt = 2;
    src_sel   = 2'd1;
    clr_cnts();
    #1;
    chk("sw_grant_same_cycle", 32'(bus.src_re), 32'h001);
    step();
    chk("drain_switching", 32'(switching), 1);
    chk("drain_lane_empty", 32'(bus.lane_empty), 32'hF);
    chk("drain_src_re", 32'(bus.src_re), 0);
    chk("drain_cur_src", 32'(cur_src), 0);
    chk("drain_old_data", 32'(bus.lane_data[7:0]), 32'hA0);
    chk("drain_word_cnt", 32'(word_cnt), 32'h0004);
    chk("drain_no_done", 32'(switch_done), 0);
    chk("drain_granted", 32'(re_s0), 1);
    step();
    chk("switch_switching", 32'(switching), 1);
    chk("switch_done_pulse", 32'(switch_done), 1);
    chk("switch_lane_empty", 32'(bus.lane_empty), 32'hF);
    chk("switch_cur_src", 32'(cur_src), 0);
    step();
    chk("post_cur_src", 32'(cur_src), 1);
    chk("post_switching", 32'(switching), 0);
    chk("post_done_low", 32'(switch_done), 0);
    chk("post_word_cnt", 32'(word_cnt), 0);
    chk("post_new_data", 32'(bus.lane_data[7:0]), 32'hB0);
    chk("post_lane_empty", 32'(bus.lane_empty), 32'hF);
    chk("post_src_re", 32'(bus.src_re), 0);

    // src_sel bounces during the change: 1 -> 0 completes, then back to 1.
    bus.lane_re = '0;
    clr_cnts();
    src_sel = 2'd0;
    step();
    chk("bounce_drain", 32'(switching), 1);
    src_sel = 2'd1;
    step();
    chk("bounce_switch_done", 32'(switch_done), 1);
    step();
    chk("bounce_first_cur", 32'(cur_src), 0);
    chk("bounce_first_run", 32'(switching), 0);
    step();
    chk("bounce_second_drain", 32'(switching), 1);
    step();
    step();
    chk("bounce_final_cur", 32'(cur_src), 1);
    chk("bounce_done_pulses", 32'(done_pulses), 2);

    // Out-of-range selection.
    src_sel = 2'd3;
    step();
    chk("selerr_set", 32'(sel_err), 1);
    chk("selerr_no_switch", 32'(switching), 0);
    chk("selerr_cur_src", 32'(cur_src), 1);
    src_sel = 2'd1;
    step();
    chk("selerr_sticky", 32'(sel_err), 1);
    chk("selerr_still_run", 32'(switching), 0);

    // Saturation: lane 2 of source 1 read for 20 cycles with a 4-bit counter.
    src_empty_drv[6] = 1'b0;
    bus.lane_re      = 4'b0100;
    clr_cnts();
    repeat (20) step();
    chk("sat_word_cnt", 32'(word_cnt), 32'h0F00);
    chk("sat_src1_reads", 32'(re_s1), 20);
    chk("sat_lane_empty", 32'(bus.lane_empty), 32'hB);
    chk("sat_lane2_data", 32'(bus.lane_data[23:16]), 32'hB2);

    // Reset in the middle of a 0 -> 1 change aborts it.
    bus.lane_re = '0;
    src_sel     = 2'd0;
    repeat (3) step();
    chk("abort_setup_cur", 32'(cur_src), 0);
    src_sel = 2'd1;
    step();
    chk("abort_in_drain", 32'(switching), 1);
    reset = 1'b1;
    step();
    chk("abort_cur_src", 32'(cur_src), 0);
    chk("abort_switching", 32'(switching), 0);
    chk("abort_no_done", 32'(switch_done), 0);
    chk("abort_sel_err_clr", 32'(sel_err), 0);
    reset   = 1'b0;
    src_sel = 2'd0;
    step();
    chk("abort_after_cur", 32'(cur_src), 0);
    chk("abort_after_run", 32'(switching), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
